// File: rtl/ysyx_23060042_ifu.sv
// Instruction fetch unit: drives a single-outstanding instruction-memory read
// port and hands one instruction at a time to the decoder with ready/valid.
module ysyx_23060042_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_err,

    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,

    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic        drop;
    logic        drop_nxt;
    logic [31:0] inst_nxt;
    logic [31:0] inst_pc_nxt;
    logic        inst_fault_nxt;
    logic        pc_aligned;

    assign pc_aligned    = (pc[1:0] == 2'b00);
    assign mem_req_valid = (state == REQ) & ~redirect_valid & pc_aligned;
    assign mem_req_addr  = pc;
    assign inst_valid    = (state == OUT) & ~redirect_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drop       <= 1'b0;
            inst       <= 32'd0;
            inst_pc    <= 32'd0;
            inst_fault <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            drop       <= drop_nxt;
            inst       <= inst_nxt;
            inst_pc    <= inst_pc_nxt;
            inst_fault <= inst_fault_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        drop_nxt       = drop;
        inst_nxt       = inst;
        inst_pc_nxt    = inst_pc;
        inst_fault_nxt = inst_fault;

        unique case (state)
            IDLE: begin
                state_nxt = REQ;
            end

            REQ: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_pc;
                end else if (!pc_aligned) begin
                    // A misaligned PC never reaches memory; it is reported as a fault.
                    state_nxt      = OUT;
                    inst_nxt       = 32'd0;
                    inst_fault_nxt = 1'b1;
                    inst_pc_nxt    = pc;
                end else if (mem_req_ready) begin
                    state_nxt = WAIT;
                end
            end

            WAIT: begin
                if (mem_resp_valid) begin
                    if (drop || redirect_valid) begin
                        // Stale response for a fetch the redirect already superseded.
                        drop_nxt  = 1'b0;
                        state_nxt = REQ;
                        if (redirect_valid) begin
                            pc_nxt = redirect_pc;
                        end
                    end else begin
                        inst_nxt       = mem_resp_data;
                        inst_fault_nxt = mem_resp_err;
                        inst_pc_nxt    = pc;
                        state_nxt      = OUT;
                    end
                end else if (redirect_valid) begin
                    // The request is still in flight: remember to discard its response.
                    pc_nxt   = redirect_pc;
                    drop_nxt = 1'b1;
                end
            end

            OUT: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = REQ;
                end else if (inst_ready) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = REQ;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060042_ifu.sv
// Directed bench for the fetch unit with a transaction-level model of the
// expected fetch stream and a latency-configurable instruction memory.
module tb_ysyx_23060042_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ysyx_23060042_ifu #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // memory / model state
    int          mem_lat    = 1;
    bit          force_resp = 1'b0;
    bit          pend       = 1'b0;
    int          pend_cnt   = 0;
    logic [31:0] pend_addr  = 32'd0;
    int          pend_epoch = 0;
    int          epoch      = 0;
    logic [31:0] exp_pc     = RESET_PC;
    bit          have_data  = 1'b0;
    bit          stall_prev = 1'b0;

    // snapshot of the last cycle's outputs
    logic        s_req_valid;
    logic [31:0] s_addr;
    logic        s_inst_valid;
    logic [31:0] s_inst;
    logic [31:0] s_inst_pc;
    logic        s_fault;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == RESET_PC) return 32'h0000_0413;
        return a ^ 32'h5A5A_0013;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a == 32'h8000_0200);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Per-cycle comparison against the fetch-stream model, then model update.
    task automatic model_check();
        if (!rst_n) begin
            chk1("rst_req_valid", mem_req_valid, 1'b0);
            chk1("rst_inst_valid", inst_valid, 1'b0);
            chk ("rst_inst", inst, 32'd0);
            chk ("rst_inst_pc", inst_pc, 32'd0);
            chk1("rst_inst_fault", inst_fault, 1'b0);
            chk ("rst_addr", mem_req_addr, RESET_PC);
            exp_pc     = RESET_PC;
            have_data  = 1'b0;
            pend       = 1'b0;
            stall_prev = 1'b0;
            epoch++;
            return;
        end
        if (redirect_valid) begin
            chk1("m_redirect_no_req", mem_req_valid, 1'b0);
            chk1("m_redirect_no_inst", inst_valid, 1'b0);
        end
        if (stall_prev && !redirect_valid) chk1("m_hold_valid", inst_valid, 1'b1);
        if (mem_req_valid) begin
            chk("m_req_addr", mem_req_addr, exp_pc);
            if (mem_req_ready) chk1("m_one_outstanding", pend, 1'b0);
        end
        if (inst_valid) begin
            chk("m_inst_pc", inst_pc, exp_pc);
            if (exp_pc[1:0] != 2'b00) begin
                chk ("m_misalign_inst", inst, 32'd0);
                chk1("m_misalign_fault", inst_fault, 1'b1);
            end else begin
                chk1("m_inst_has_data", have_data, 1'b1);
                chk ("m_inst", inst, mem_word(exp_pc));
                chk1("m_inst_fault", inst_fault, mem_err(exp_pc));
            end
        end
        stall_prev = inst_valid && !inst_ready && !redirect_valid;
        // model update for the coming edge
        if (mem_resp_valid && pend) begin
            pend = 1'b0;
            if (pend_epoch == epoch && pend_addr == exp_pc && !redirect_valid) have_data = 1'b1;
        end else if (pend && pend_cnt > 1) begin
            pend_cnt--;
        end
        if (mem_req_valid && mem_req_ready) begin
            pend       = 1'b1;
            pend_addr  = mem_req_addr;
            pend_cnt   = mem_lat;
            pend_epoch = epoch;
        end
        if (redirect_valid) begin
            exp_pc    = redirect_pc;
            have_data = 1'b0;
            epoch++;
        end else if (inst_valid && inst_ready) begin
            exp_pc    = exp_pc + 32'd4;
            have_data = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (force_resp) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEAD_BEEF;
            mem_resp_err   = 1'b1;
        end else if (rst_n && pend && pend_cnt == 1) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_word(pend_addr);
            mem_resp_err   = mem_err(pend_addr);
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = 32'd0;
            mem_resp_err   = 1'b0;
        end
        #2;
        model_check();
        s_req_valid  = mem_req_valid;
        s_addr       = mem_req_addr;
        s_inst_valid = inst_valid;
        s_inst       = inst;
        s_inst_pc    = inst_pc;
        s_fault      = inst_fault;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_inst(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            cycle();
            if (s_inst_valid) return;
        end
        chk1(name, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n          = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'd0;
        mem_resp_err   = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        repeat (3) cycle();

        // boot and best-case latency
        rst_n = 1'b1;
        cycle(); chk1("boot_idle_no_req", s_req_valid, 1'b0);
        cycle(); chk1("boot_req_valid", s_req_valid, 1'b1);
                 chk ("boot_req_addr", s_addr, 32'h8000_0000);
        cycle(); chk1("lat_n1_no_inst", s_inst_valid, 1'b0);
                 chk1("lat_n1_no_req", s_req_valid, 1'b0);
        cycle(); chk1("lat_n2_inst_valid", s_inst_valid, 1'b1);
                 chk ("lat_n2_inst", s_inst, 32'h0000_0413);
                 chk ("lat_n2_inst_pc", s_inst_pc, 32'h8000_0000);
                 chk1("lat_n2_fault", s_fault, 1'b0);
        inst_ready = 1'b0;
        cycle(); chk1("lat_n3_req_valid", s_req_valid, 1'b1);
                 chk ("lat_n3_req_addr", s_addr, 32'h8000_0004);

        // decoder backpressure for 5 cycles
        wait_inst("stall_timeout", 8);
        chk("stall0_inst", s_inst, 32'hDA5A_0017);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk1("stall_valid", s_inst_valid, 1'b1);
            chk ("stall_inst", s_inst, 32'hDA5A_0017);
            chk ("stall_inst_pc", s_inst_pc, 32'h8000_0004);
            chk1("stall_no_req", s_req_valid, 1'b0);
        end
        mem_lat    = 2;
        inst_ready = 1'b1;
        cycle(); chk1("stall_release_valid", s_inst_valid, 1'b1);
        cycle(); chk ("stall_next_addr", s_addr, 32'h8000_0008);

        // redirect while the fetch is in flight
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        cycle(); chk1("wait_redir_no_inst", s_inst_valid, 1'b0);
        redirect_valid = 1'b0; mem_lat = 1;
        cycle(); chk1("drop_no_inst", s_inst_valid, 1'b0);
                 chk1("drop_no_req", s_req_valid, 1'b0);
        cycle(); chk1("drop_next_req", s_req_valid, 1'b1);
                 chk ("drop_next_addr", s_addr, 32'h8000_0100);
        inst_ready = 1'b0;
        wait_inst("redir_fetch_timeout", 6);
        chk("redir_inst_pc", s_inst_pc, 32'h8000_0100);

        // redirect out of OUT to a misaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0102; inst_ready = 1'b1;
        cycle(); chk1("out_redir_no_inst", s_inst_valid, 1'b0);
        redirect_valid = 1'b0;
        cycle(); chk1("misalign_no_req", s_req_valid, 1'b0);
        cycle(); chk1("misalign_valid", s_inst_valid, 1'b1);
                 chk ("misalign_inst", s_inst, 32'd0);
                 chk1("misalign_fault", s_fault, 1'b1);
                 chk ("misalign_pc", s_inst_pc, 32'h8000_0102);

        // memory access fault
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        cycle(); chk1("req_redir_no_req", s_req_valid, 1'b0);
        redirect_valid = 1'b0;
        cycle(); chk ("err_req_addr", s_addr, 32'h8000_0200);
        cycle();
        cycle(); chk1("err_valid", s_inst_valid, 1'b1);
                 chk1("err_fault", s_fault, 1'b1);
                 chk ("err_inst_pc", s_inst_pc, 32'h8000_0200);
                 chk ("err_inst", s_inst, 32'hDA5A_0213);
        cycle(); chk ("err_next_addr", s_addr, 32'h8000_0204);

        // redirect coinciding with the response, then PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cycle(); chk1("resp_redir_no_inst", s_inst_valid, 1'b0);
        redirect_valid = 1'b0;
        cycle(); chk ("wrap_req_addr", s_addr, 32'hFFFF_FFFC);
        cycle();
        cycle(); chk ("wrap_inst", s_inst, 32'hA5A5_FFEF);
                 chk ("wrap_inst_pc", s_inst_pc, 32'hFFFF_FFFC);
        cycle(); chk1("wrap_req_valid", s_req_valid, 1'b1);
                 chk ("wrap_next_addr", s_addr, 32'h0000_0000);

        // reset in WAIT with a late response
        rst_n = 1'b0; force_resp = 1'b1;
        cycle(); chk1("mid_rst_no_inst", s_inst_valid, 1'b0);
                 chk ("mid_rst_inst", s_inst, 32'd0);
        force_resp = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle(); chk1("rerun_idle", s_req_valid, 1'b0);
        cycle(); chk1("rerun_req_valid", s_req_valid, 1'b1);
                 chk ("rerun_addr", s_addr, 32'h8000_0000);
        wait_inst("rerun_timeout", 6);
        chk("rerun_inst", s_inst, 32'h0000_0413);
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
